spi_dev_sound_cmd_rx: RTL and testbench

//  Host-to-FPGA counterpart of the sound-event responder on the SPI protocol wrapper.

---
 rtl/spi_dev_sound_cmd_rx.sv | 188 ++++++++++++++++++
 tb/tb_spi_dev_sound_cmd_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dev_sound_cmd_rx.sv
// spi_dev_sound_cmd_rx
// Receives sound-control write commands from the SPI protocol wrapper and
// queues each complete request (sound id, volume) in a small FIFO.
// The audio engine drains the queue over a valid/ready stream. A status
// command reads back the queue level and a sticky overflow flag.

module spi_dev_sound_cmd_rx #(
    parameter logic [7:0] CMD_SOUND_CTRL = 8'hfb,
    parameter logic [7:0] CMD_RX_STATUS  = 8'hfc,
    parameter int         FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pw_wdata,
    input  logic       pw_wcmd,
    input  logic       pw_wstb,
    input  logic       pw_end,
    output logic       pw_req,
    input  logic       pw_gnt,
    output logic [7:0] pw_rdata,
    output logic       pw_rstb,
    output logic       pw_irq,
    output logic [7:0] evt_sound_id,
    output logic [7:0] evt_volume,
    output logic       evt_valid,
    input  logic       evt_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    // Command decode and command-active flags
    logic          cmdStbSound_q, cmdStbSound_d;
    logic          cmdStbStatus_q, cmdStbStatus_d;
    logic          actSound_q, actSound_d;
    logic          actStatus_q, actStatus_d;

    // Payload capture
    logic [1:0]    byteIdx_q, byteIdx_d;
    logic [7:0]    idReg_q, idReg_d;
    logic          pushPend_q, pushPend_d;
    logic [15:0]   pushData_q, pushData_d;

    // Request queue
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;

    // Status response
    logic          txDone_q, txDone_d;
    logic          rstb_q, rstb_d;
    logic [7:0]    rdata_q, rdata_d;

    logic          full;
    logic          empty;
    logic          pop;
    logic          pushOk;
    logic          pushDrop;
    logic          sendStatus;
    logic [3:0]    level4;

    assign full       = (level_q == LW'(FIFO_DEPTH));
    assign empty      = (level_q == '0);
    assign pop        = ~empty & evt_ready;
    assign pushOk     = pushPend_q & (~full | pop);
    assign pushDrop   = pushPend_q & full & ~pop;
    assign sendStatus = pw_gnt & actStatus_q & ~txDone_q;
    assign level4     = 4'(level_q);

    assign pw_req       = actStatus_q;
    assign pw_rdata     = rdata_q;
    assign pw_rstb      = rstb_q;
    assign pw_irq       = ovf_q;
    assign evt_valid    = ~empty;
    assign evt_sound_id = empty ? 8'h00 : mem_q[rdPtr_q][15:8];
    assign evt_volume   = empty ? 8'h00 : mem_q[rdPtr_q][7:0];

    // Decode command bytes and track which command is active in this transaction
    always_comb begin
        cmdStbSound_d  = pw_wstb & pw_wcmd & (pw_wdata == CMD_SOUND_CTRL);
        cmdStbStatus_d = pw_wstb & pw_wcmd & (pw_wdata == CMD_RX_STATUS);
        actSound_d     = (actSound_q & ~pw_end) | cmdStbSound_q;
        actStatus_d    = (actStatus_q & ~pw_end) | cmdStbStatus_q;
    end

    // Collect the two payload bytes; a command byte or end of transaction restarts capture
    always_comb begin
        byteIdx_d  = byteIdx_q;
        idReg_d    = idReg_q;
        pushPend_d = 1'b0;
        pushData_d = pushData_q;
        if ((pw_wstb & pw_wcmd) | cmdStbSound_q | pw_end) begin
            byteIdx_d = 2'd0;
        end else if (pw_wstb & ~pw_wcmd & actSound_q) begin
            case (byteIdx_q)
                2'd0: begin
                    idReg_d   = pw_wdata;
                    byteIdx_d = 2'd1;
                end
                2'd1: begin
                    pushPend_d = 1'b1;
                    pushData_d = {idReg_q, pw_wdata};
                    byteIdx_d  = 2'd2;
                end
                default: byteIdx_d = 2'd2;
            endcase
        end
    end

    // Queue pointers, level and sticky overflow (a new overflow beats the read-clear)
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (pushOk) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        case ({pushOk, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (pushDrop) begin
            ovf_d = 1'b1;
        end else if (sendStatus) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Send exactly one status byte per grant; re-arm once the grant drops
    always_comb begin
        txDone_d = pw_gnt ? (txDone_q | sendStatus) : 1'b0;
        rstb_d   = sendStatus;
        rdata_d  = sendStatus ? {ovf_q, 3'b000, level4} : 8'h00;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cmdStbSound_q  <= 1'b0;
            cmdStbStatus_q <= 1'b0;
            actSound_q     <= 1'b0;
            actStatus_q    <= 1'b0;
            byteIdx_q      <= 2'd0;
            idReg_q        <= 8'h00;
            pushPend_q     <= 1'b0;
            pushData_q     <= 16'h0000;
            wrPtr_q        <= '0;
            rdPtr_q        <= '0;
            level_q        <= '0;
            ovf_q          <= 1'b0;
            txDone_q       <= 1'b0;
            rstb_q         <= 1'b0;
            rdata_q        <= 8'h00;
        end else begin
            cmdStbSound_q  <= cmdStbSound_d;
            cmdStbStatus_q <= cmdStbStatus_d;
            actSound_q     <= actSound_d;
            actStatus_q    <= actStatus_d;
            byteIdx_q      <= byteIdx_d;
            idReg_q        <= idReg_d;
            pushPend_q     <= pushPend_d;
            pushData_q     <= pushData_d;
            wrPtr_q        <= wrPtr_d;
            rdPtr_q        <= rdPtr_d;
            level_q        <= level_d;
            ovf_q          <= ovf_d;
            txDone_q       <= txDone_d;
            rstb_q         <= rstb_d;
            rdata_q        <= rdata_d;
        end
    end

    // Queue storage; contents need no reset because the level gates visibility
    always_ff @(posedge clk) begin
        if (!rst && pushOk) begin
            mem_q[wrPtr_q] <= pushData_q;
        end
    end

endmodule

// File: tb/tb_spi_dev_sound_cmd_rx.sv
// Testbench for spi_dev_sound_cmd_rx: scoreboard of queued requests,
// status readback and overflow/reset corner cases.

module tb_spi_dev_sound_cmd_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pw_wdata;
    logic       pw_wcmd;
    logic       pw_wstb;
    logic       pw_end;
    logic       pw_req;
    logic       pw_gnt;
    logic [7:0] pw_rdata;
    logic       pw_rstb;
    logic       pw_irq;
    logic [7:0] evt_sound_id;
    logic [7:0] evt_volume;
    logic       evt_valid;
    logic       evt_ready;

    int          totalChecks = 0;
    int          badChecks   = 0;
    logic [15:0] sb[$];
    int          modelLevel  = 0;

    always #5 clk = ~clk;

    spi_dev_sound_cmd_rx dut (
        .clk          (clk),
        .rst          (rst),
        .pw_wdata     (pw_wdata),
        .pw_wcmd      (pw_wcmd),
        .pw_wstb      (pw_wstb),
        .pw_end       (pw_end),
        .pw_req       (pw_req),
        .pw_gnt       (pw_gnt),
        .pw_rdata     (pw_rdata),
        .pw_rstb      (pw_rstb),
        .pw_irq       (pw_irq),
        .evt_sound_id (evt_sound_id),
        .evt_volume   (evt_volume),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One wrapper byte strobe followed by an idle gap, as SPI bytes are spaced out
    task automatic applyStimulus(input logic [7:0] data, input logic isCmd);
        @(negedge clk);
        pw_wdata = data;
        pw_wcmd  = isCmd;
        pw_wstb  = 1'b1;
        @(negedge clk);
        pw_wstb  = 1'b0;
        pw_wcmd  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic endTxn();
        @(negedge clk);
        pw_end = 1'b1;
        @(negedge clk);
        pw_end = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Full sound write; the model decides whether the entry fits
    task automatic writeReq(input logic [7:0] id, input logic [7:0] vol);
        applyStimulus(8'hfb, 1'b1);
        applyStimulus(id, 1'b0);
        applyStimulus(vol, 1'b0);
        endTxn();
        if (modelLevel < 4) begin
            sb.push_back({id, vol});
            modelLevel++;
        end
    endtask

    // Wait (bounded) for the head entry, compare with scoreboard, then pop it
    task automatic popEntry(input string tag);
        logic [15:0] exp;
        int          waited;
        waited = 0;
        while (!evt_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_valid"}, 32'(evt_valid), 32'd1);
        if (sb.size() == 0) begin
            checkOutput({tag, "_sbEmpty"}, 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            checkOutput({tag, "_entry"}, {16'h0, evt_sound_id, evt_volume}, {16'h0, exp});
        end
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        modelLevel--;
    endtask

    // Status read: expect exactly one strobe carrying the expected byte
    task automatic readStatus(input string tag, input logic [7:0] expected);
        int         strobes;
        logic [7:0] got;
        strobes = 0;
        got     = 8'h00;
        applyStimulus(8'hfc, 1'b1);
        checkOutput({tag, "_req"}, 32'(pw_req), 32'd1);
        pw_gnt = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (pw_rstb) begin
                strobes++;
                got = pw_rdata;
            end
        end
        pw_gnt = 1'b0;
        endTxn();
        checkOutput({tag, "_strobes"}, 32'(strobes), 32'd1);
        checkOutput({tag, "_rdata"}, 32'(got), 32'(expected));
        checkOutput({tag, "_reqOff"}, 32'(pw_req), 32'd0);
        checkOutput({tag, "_rdataIdle"}, 32'(pw_rdata), 32'd0);
    endtask

    initial begin
        logic [7:0] headId;
        rst       = 1'b1;
        pw_wdata  = 8'h00;
        pw_wcmd   = 1'b0;
        pw_wstb   = 1'b0;
        pw_end    = 1'b0;
        pw_gnt    = 1'b0;
        evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        checkOutput("rst_valid", 32'(evt_valid), 32'd0);
        checkOutput("rst_out", {8'h0, evt_sound_id, evt_volume, pw_rdata}, 32'd0);
        checkOutput("rst_ctl", {29'd0, pw_req, pw_rstb, pw_irq}, 32'd0);

        // 1: single request and pop
        writeReq(8'h12, 8'h80);
        popEntry("t1");
        checkOutput("t1_emptyAfter", 32'(evt_valid), 32'd0);

        // 2: five writes into a depth-4 queue with no consumer
        for (int i = 0; i < 5; i++) begin
            writeReq(8'h20 + 8'(i), 8'h40 + 8'(i));
        end
        checkOutput("t2_irq", 32'(pw_irq), 32'd1);
        headId = evt_sound_id;
        repeat (4) @(negedge clk);
        checkOutput("t2_holdHead", 32'(evt_sound_id), 32'(headId));

        // 3: status read reports ovf and level 4, then clears ovf
        readStatus("t3", 8'h84);
        checkOutput("t3_irqClr", 32'(pw_irq), 32'd0);
        for (int i = 0; i < 4; i++) begin
            popEntry("t2_drain");
        end
        checkOutput("t2_drained", 32'(evt_valid), 32'd0);

        // 4: partial write discarded, then a clean one
        applyStimulus(8'hfb, 1'b1);
        applyStimulus(8'h33, 1'b0);
        endTxn();
        checkOutput("t4_noPush", 32'(evt_valid), 32'd0);
        writeReq(8'h44, 8'h55);
        popEntry("t4");
        checkOutput("t4_single", 32'(evt_valid), 32'd0);

        // 5: fill queue, then push coincides with a pop
        for (int i = 0; i < 4; i++) begin
            writeReq(8'h60 + 8'(i), 8'h70 + 8'(i));
        end
        applyStimulus(8'hfb, 1'b1);
        applyStimulus(8'h6a, 1'b0);
        @(negedge clk);
        pw_wdata = 8'h7a;
        pw_wstb  = 1'b1;
        @(negedge clk);
        pw_wstb  = 1'b0;
        checkOutput("t5_head", {16'h0, evt_sound_id, evt_volume}, {16'h0, sb[0]});
        void'(sb.pop_front());
        sb.push_back(16'h6a7a);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        endTxn();
        checkOutput("t5_irq", 32'(pw_irq), 32'd0);
        readStatus("t5", 8'h04);
        for (int i = 0; i < 4; i++) begin
            popEntry("t5_drain");
        end
        checkOutput("t5_drained", 32'(evt_valid), 32'd0);

        // 6: reset between payload bytes
        applyStimulus(8'hfb, 1'b1);
        applyStimulus(8'h66, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h77, 1'b0);
        endTxn();
        checkOutput("t6_valid", 32'(evt_valid), 32'd0);
        checkOutput("t6_out", {8'h0, evt_sound_id, evt_volume, pw_rdata}, 32'd0);
        checkOutput("t6_ctl", {29'd0, pw_req, pw_rstb, pw_irq}, 32'd0);
        modelLevel = 0;
        writeReq(8'h88, 8'h99);
        popEntry("t6");
        checkOutput("t6_empty", 32'(evt_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
